// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS-subset controller.
//   State encoding, ALUctr codes, Op/Funct constants, op-class enumeration
//   and the Op -> op-class classifier.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTR_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // ALUctr codes
  localparam logic [ALUCTR_W-1:0] ALU_ADDU = 3'b000;
  localparam logic [ALUCTR_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALUCTR_W-1:0] ALU_OR   = 3'b010;
  localparam logic [ALUCTR_W-1:0] ALU_SUBU = 3'b100;
  localparam logic [ALUCTR_W-1:0] ALU_SUB  = 3'b101;
  localparam logic [ALUCTR_W-1:0] ALU_SLTU = 3'b110;
  localparam logic [ALUCTR_W-1:0] ALU_SLT  = 3'b111;

  // Op field values
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // Funct field values for R-type
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    OPC_NONE  = 4'd0,
    OPC_R     = 4'd1,
    OPC_LW    = 4'd2,
    OPC_SW    = 4'd3,
    OPC_ADDI  = 4'd4,
    OPC_ADDIU = 4'd5,
    OPC_ORI   = 4'd6,
    OPC_BEQ   = 4'd7,
    OPC_J     = 4'd8
  } op_class_e;

  // Classify the Op field; unsupported opcodes map to OPC_NONE.
  function automatic op_class_e op_class_f(input logic [OP_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_RTYPE: cls = OPC_R;
      OP_LW:    cls = OPC_LW;
      OP_SW:    cls = OPC_SW;
      OP_ADDI:  cls = OPC_ADDI;
      OP_ADDIU: cls = OPC_ADDIU;
      OP_ORI:   cls = OPC_ORI;
      OP_BEQ:   cls = OPC_BEQ;
      OP_J:     cls = OPC_J;
      default:  cls = OPC_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU control decoder.
//   r_mode_i   : 1 = decode Funct (R-type execute), 0 = decode op class
//   funct_i    : instruction[5:0]
//   op_class_i : op class latched in DECODE
//   alu_ctr_o  : ALUctr code
//   ext_op_o   : sign-extend immediate (I-type only)
//   funct_ok_o : Funct is a supported R-type function (valid in r_mode_i)
module mc_aludec
  import mc_pkg::*;
(
  input  logic                r_mode_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  op_class_e           op_class_i,
  output logic [ALUCTR_W-1:0] alu_ctr_o,
  output logic                ext_op_o,
  output logic                funct_ok_o
);

  always_comb begin
    alu_ctr_o  = ALU_ADDU;
    ext_op_o   = 1'b0;
    funct_ok_o = 1'b0;
    if (r_mode_i) begin
      funct_ok_o = 1'b1;
      case (funct_i)
        F_ADDU:  alu_ctr_o = ALU_ADDU;
        F_ADD:   alu_ctr_o = ALU_ADD;
        F_SUBU:  alu_ctr_o = ALU_SUBU;
        F_SUB:   alu_ctr_o = ALU_SUB;
        F_OR:    alu_ctr_o = ALU_OR;
        F_SLTU:  alu_ctr_o = ALU_SLTU;
        F_SLT:   alu_ctr_o = ALU_SLT;
        default: funct_ok_o = 1'b0;
      endcase
    end else begin
      case (op_class_i)
        OPC_ADDI: begin
          alu_ctr_o = ALU_ADD;
          ext_op_o  = 1'b1;
        end
        OPC_ADDIU: begin
          alu_ctr_o = ALU_ADDU;
          ext_op_o  = 1'b1;
        end
        OPC_ORI:  alu_ctr_o = ALU_OR;
        default:  alu_ctr_o = ALU_ADDU;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore control FSM for a multicycle MIPS-subset datapath.
//   Inputs : clk, rst_n (sync, active-low), Op, Funct, Overflow, MemReady
//   Outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
//            MemtoReg, RegWrite, ALUSrcA, ExtOp, Illegal, ALUSrcB[1:0],
//            PCSource[1:0], ALUctr[2:0], State[3:0] (debug)
//   Outputs decode the registered state and latched op class; FETCH/MEM
//   strobes follow MemReady and the DECODE/R_EXEC Illegal flag follows IR.
module mc_control
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     Op,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic                Overflow,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                ExtOp,
  output logic                Illegal,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [STATE_W-1:0]  State
);

  state_e    state_q, state_d, st;
  op_class_e op_class_q, op_class_d;
  logic      ovf_hold_q, ovf_hold_d;
  logic      mem_rdy;

  logic [ALUCTR_W-1:0] dec_alu_ctr;
  logic                dec_ext_op;
  logic                dec_funct_ok;

  // While reset is held the outputs present FETCH with MemReady masked.
  assign st      = rst_n ? state_q : S_FETCH;
  assign mem_rdy = MemReady & rst_n;

  mc_aludec u_aludec (
    .r_mode_i   (st == S_R_EXEC),
    .funct_i    (Funct),
    .op_class_i (op_class_q),
    .alu_ctr_o  (dec_alu_ctr),
    .ext_op_o   (dec_ext_op),
    .funct_ok_o (dec_funct_ok)
  );

  // State, op class and overflow hold registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      op_class_q <= OPC_NONE;
      ovf_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_class_q <= op_class_d;
      ovf_hold_q <= ovf_hold_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    op_class_d  = op_class_q;
    ovf_hold_d  = ovf_hold_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ExtOp       = 1'b0;
    Illegal     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUctr      = ALU_ADDU;
    State       = STATE_W'(st);

    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_rdy) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        op_class_d = op_class_f(Op);
        case (op_class_f(Op))
          OPC_LW, OPC_SW:              state_d = S_MEM_ADDR;
          OPC_R:                       state_d = S_R_EXEC;
          OPC_ADDI, OPC_ADDIU, OPC_ORI: state_d = S_I_EXEC;
          OPC_BEQ:                     state_d = S_BRANCH;
          OPC_J:                       state_d = S_JUMP;
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        state_d = (op_class_q == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUctr     = dec_alu_ctr;
        ovf_hold_d = Overflow;
        if (dec_funct_ok) begin
          state_d = S_R_WB;
        end else begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_I_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUctr     = dec_alu_ctr;
        ExtOp      = dec_ext_op;
        ovf_hold_d = Overflow;
        state_d    = S_I_WB;
      end
      // Writeback is suppressed when the execute cycle flagged overflow.
      S_R_WB: begin
        RegWrite = ~ovf_hold_q;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_I_WB: begin
        RegWrite = ~ovf_hold_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUctr      = ALU_SUBU;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. Each task queues per-cycle
// stimulus with the expected output vector, then replays the queue and
// compares DUT outputs at the falling edge.
module tb_mc_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Overflow = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUctr;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  // Strobe bit masks: PCW PCWC IORD MRD MWR IRW RDST M2R RW SRCA EXT ILL
  localparam logic [11:0] PCW  = 12'h800;
  localparam logic [11:0] PCWC = 12'h400;
  localparam logic [11:0] IORD = 12'h200;
  localparam logic [11:0] MRD  = 12'h100;
  localparam logic [11:0] MWR  = 12'h080;
  localparam logic [11:0] IRW  = 12'h040;
  localparam logic [11:0] RDST = 12'h020;
  localparam logic [11:0] M2R  = 12'h010;
  localparam logic [11:0] RW   = 12'h008;
  localparam logic [11:0] SRCA = 12'h004;
  localparam logic [11:0] EXT  = 12'h002;
  localparam logic [11:0] ILL  = 12'h001;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        ovf;
    logic        mr;
    logic [22:0] exp;
    string       tag;
  } step_t;

  step_t sb_q[$];
  logic [22:0] obs;

  assign obs = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp, Illegal,
                ALUSrcB, PCSource, ALUctr};

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Overflow(Overflow),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ExtOp(ExtOp), .Illegal(Illegal), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUctr(ALUctr), .State(State)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] ev(input state_e st, input logic [11:0] s,
                                     input logic [1:0] b, input logic [1:0] p,
                                     input logic [2:0] a);
    return {4'(st), s, b, p, a};
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                      input logic ovf, input logic mr, input logic [22:0] exp,
                      input string tag);
    step_t s;
    s.rst = rst; s.op = op; s.funct = funct; s.ovf = ovf; s.mr = mr;
    s.exp = exp; s.tag = tag;
    sb_q.push_back(s);
  endtask

  // Common prefix: FETCH (MemReady=1) then a legal DECODE
  task automatic push_fd(input logic [5:0] op, input logic [5:0] funct, input string tag);
    push(1'b1, op, funct, 1'b0, 1'b1, ev(S_FETCH, MRD | IRW | PCW, 2'b01, 2'b00, 3'b000), {tag, ".fetch"});
    push(1'b1, op, funct, 1'b0, 1'b1, ev(S_DECODE, 12'h000, 2'b11, 2'b00, 3'b000), {tag, ".decode"});
  endtask

  task automatic push_r(input logic [5:0] funct, input logic [2:0] alu, input string tag);
    push_fd(OP_RTYPE, funct, tag);
    push(1'b1, OP_RTYPE, funct, 1'b0, 1'b1, ev(S_R_EXEC, SRCA, 2'b00, 2'b00, alu), {tag, ".rexec"});
    push(1'b1, OP_RTYPE, funct, 1'b0, 1'b1, ev(S_R_WB, RDST | RW, 2'b00, 2'b00, 3'b000), {tag, ".rwb"});
  endtask

  task automatic test_reset();
    step_t s;
    push(1'b0, OP_RTYPE, F_ADDU, 1'b0, 1'b1, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "rst.hold0");
    push(1'b0, OP_LW, F_ADDU, 1'b0, 1'b1, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "rst.hold1");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.ovf_hold_q !== 1'b0) begin failures++; $display("FAIL rst.ovfhold got=%b exp=0", dut.ovf_hold_q); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    step_t s;
    push_r(F_ADDU, ALU_ADDU, "addu");
    push_r(F_SLT, ALU_SLT, "slt");
    push_r(F_SLTU, ALU_SLTU, "sltu");
    push_r(F_SUB, ALU_SUB, "sub");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_ovf();
    step_t s;
    push_fd(OP_RTYPE, F_ADD, "addovf");
    push(1'b1, OP_RTYPE, F_ADD, 1'b1, 1'b1, ev(S_R_EXEC, SRCA, 2'b00, 2'b00, ALU_ADD), "addovf.rexec");
    push(1'b1, OP_RTYPE, F_ADD, 1'b0, 1'b1, ev(S_R_WB, RDST, 2'b00, 2'b00, 3'b000), "addovf.rwb");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.ovf_hold_q !== 1'b1) begin failures++; $display("FAIL addovf.hold got=%b exp=1", dut.ovf_hold_q); end
  endtask

  task automatic test_lw_wait();
    step_t s;
    push_fd(OP_LW, 6'd0, "lw");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_ADDR, SRCA | EXT, 2'b10, 2'b00, 3'b000), "lw.addr");
    for (int i = 0; i < 3; i++)
      push(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, ev(S_MEM_RD, IORD | MRD, 2'b00, 2'b00, 3'b000), "lw.wait");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_RD, IORD | MRD, 2'b00, 2'b00, 3'b000), "lw.rd");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_WB, RW | M2R, 2'b00, 2'b00, 3'b000), "lw.wb");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_imm();
    step_t s;
    push_fd(OP_BEQ, 6'd0, "beq");
    push(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b1, ev(S_BRANCH, SRCA | PCWC, 2'b00, 2'b01, ALU_SUBU), "beq.br");
    push_fd(OP_ORI, 6'd0, "ori");
    push(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, ev(S_I_EXEC, SRCA, 2'b10, 2'b00, ALU_OR), "ori.iexec");
    push(1'b1, OP_ORI, 6'd0, 1'b0, 1'b1, ev(S_I_WB, RW, 2'b00, 2'b00, 3'b000), "ori.iwb");
    push_fd(OP_ADDI, 6'd0, "addi");
    push(1'b1, OP_ADDI, 6'd0, 1'b1, 1'b1, ev(S_I_EXEC, SRCA | EXT, 2'b10, 2'b00, ALU_ADD), "addi.iexec");
    push(1'b1, OP_ADDI, 6'd0, 1'b0, 1'b1, ev(S_I_WB, 12'h000, 2'b00, 2'b00, 3'b000), "addi.iwb");
    push_fd(OP_ADDIU, 6'd0, "addiu");
    push(1'b1, OP_ADDIU, 6'd0, 1'b0, 1'b1, ev(S_I_EXEC, SRCA | EXT, 2'b10, 2'b00, ALU_ADDU), "addiu.iexec");
    push(1'b1, OP_ADDIU, 6'd0, 1'b0, 1'b1, ev(S_I_WB, RW, 2'b00, 2'b00, 3'b000), "addiu.iwb");
    push_fd(OP_J, 6'd0, "j");
    push(1'b1, OP_J, 6'd0, 1'b0, 1'b1, ev(S_JUMP, PCW, 2'b00, 2'b10, 3'b000), "j.jump");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t s;
    push(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, ev(S_FETCH, MRD | IRW | PCW, 2'b01, 2'b00, 3'b000), "illop.fetch");
    push(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, ev(S_DECODE, ILL, 2'b11, 2'b00, 3'b000), "illop.decode");
    push(1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "illop.back");
    push(1'b1, OP_RTYPE, 6'b000000, 1'b0, 1'b1, ev(S_FETCH, MRD | IRW | PCW, 2'b01, 2'b00, 3'b000), "illfn.fetch");
    push(1'b1, OP_RTYPE, 6'b000000, 1'b0, 1'b1, ev(S_DECODE, 12'h000, 2'b11, 2'b00, 3'b000), "illfn.decode");
    push(1'b1, OP_RTYPE, 6'b000000, 1'b0, 1'b1, ev(S_R_EXEC, SRCA | ILL, 2'b00, 2'b00, 3'b000), "illfn.rexec");
    push(1'b1, OP_RTYPE, 6'b000000, 1'b0, 1'b0, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "illfn.back");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sw();
    step_t s;
    push_fd(OP_SW, 6'd0, "swrst");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, ev(S_MEM_ADDR, SRCA | EXT, 2'b10, 2'b00, 3'b000), "swrst.addr");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, ev(S_MEM_WR, IORD | MWR, 2'b00, 2'b00, 3'b000), "swrst.wait0");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, ev(S_MEM_WR, IORD | MWR, 2'b00, 2'b00, 3'b000), "swrst.wait1");
    push(1'b0, OP_SW, 6'd0, 1'b0, 1'b1, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "swrst.inrst");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, ev(S_FETCH, MRD, 2'b01, 2'b00, 3'b000), "swrst.after");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.ovf_hold_q !== 1'b0) begin failures++; $display("FAIL swrst.ovfhold got=%b exp=0", dut.ovf_hold_q); end
  endtask

  task automatic test_back_to_back();
    step_t s;
    push_fd(OP_SW, 6'd0, "sw");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, ev(S_MEM_ADDR, SRCA | EXT, 2'b10, 2'b00, 3'b000), "sw.addr");
    push(1'b1, OP_SW, 6'd0, 1'b0, 1'b1, ev(S_MEM_WR, IORD | MWR, 2'b00, 2'b00, 3'b000), "sw.wr");
    push_fd(OP_LW, 6'd0, "lw2");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_ADDR, SRCA | EXT, 2'b10, 2'b00, 3'b000), "lw2.addr");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_RD, IORD | MRD, 2'b00, 2'b00, 3'b000), "lw2.rd");
    push(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, ev(S_MEM_WB, RW | M2R, 2'b00, 2'b00, 3'b000), "lw2.wb");
    push_r(F_OR, ALU_OR, "or");
    push_r(F_SUBU, ALU_SUBU, "subu");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      rst_n = s.rst; Op = s.op; Funct = s.funct; Overflow = s.ovf; MemReady = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_add_ovf();
    test_lw_wait();
    test_branch_imm();
    test_illegal();
    test_add_ovf();
    test_reset_mid_sw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 Op  input  6  instruction[31:26] from instruction register.
REQ-004 Funct  input  6  instruction[5:0] from instruction register.
REQ-005 Overflow  input  1  ALU signed-overflow flag, combinational, valid in the execute state.
REQ-006 MemReady  input  1  memory handshake; access completes in the cycle where it is 1.
REQ-007 Outputs, all 1 bit unless noted: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp, Illegal; ALUSrcB 2; PCSource 2; ALUctr 3 (feeds ALU); State 4 (debug).

Function
REQ-010 Moore FSM; every output is a pure function of the registered state plus the op class latched in DECODE; the only exception is OvfHold, whose use is defined in REQ-020.
REQ-011 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-012 ALUctr encoding:
- 000 addu
- 001 add (overflow checked)
- 010 or
- 100 subu
- 101 sub (overflow checked)
- 110 sltu
- 111 slt
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=000.
- IRWrite=1 and PCWrite=1 only when MemReady=1; otherwise stay in FETCH.
- Next state is DECODE when MemReady=1.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUctr=000 (branch target); next state by Op:
- 100011/101011 -> MEM_ADDR
- 000000 -> R_EXEC
- 001000/001001/001101 -> I_EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- any other Op -> FETCH with Illegal=1 for that single cycle.
REQ-015 R_EXEC: ALUSrcA=1, ALUSrcB=00. ALUctr by Funct:
- 100001 -> 000
- 100000 -> 001
- 100011 -> 100
- 100010 -> 101
- 100101 -> 010
- 101011 -> 110
- 101010 -> 111
- any other Funct -> Illegal=1 for one cycle, next state FETCH, no writeback.
REQ-016 I_EXEC: ALUSrcA=1, ALUSrcB=10. By Op:
- addi: ALUctr=001, ExtOp=1
- addiu: ALUctr=000, ExtOp=1
- ori: ALUctr=010, ExtOp=0
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=000; next state MEM_RD for lw, MEM_WR for sw.
REQ-018 MEM_RD (IorD=1, MemRead=1) and MEM_WR (IorD=1, MemWrite=1) hold until MemReady=1.
- MEM_RD then goes to MEM_WB; MEM_WR then goes to FETCH.
- MemWrite shall stay asserted on every wait cycle.
REQ-019 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-020 At the end of R_EXEC/I_EXEC, OvfHold register <= Overflow.
- R_WB/I_WB: RegWrite = !OvfHold; RegDst=1 in R_WB, 0 in I_WB; MemtoReg=0; next state FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctr=100, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-023 All outputs not listed for a state are 0 in that state; ALUSrcB, PCSource and ALUctr default to 00/00/000.
REQ-024 Latency in cycles, with MemReady tied high: R/I = 4, lw = 5, sw = 4, beq = 3, j = 3.

Reset
REQ-030 When rst_n=0 at a rising edge: State=FETCH, OvfHold=0, latched op class cleared.
REQ-031 Reset asserted mid-instruction (including memory wait states) aborts the instruction; no RegWrite or MemWrite is issued in the cycle after reset.
REQ-032 While in reset, all outputs reflect FETCH with MemReady ignored: PCWrite=0, IRWrite=0.

Structure
REQ-040 Shared package mc_pkg holds: state encoding (4-bit enumeration), ALUctr codes, Op and Funct constants.
REQ-041 One sub-module, mc_aludec: combinational Funct/Op-class -> ALUctr decoder; the FSM is the only sequential logic.

Verification
REQ-050 Reset, then addu with MemReady=1 -> states FETCH, DECODE, R_EXEC, R_WB; ALUctr=000 in R_EXEC; RegWrite=1, RegDst=1 in R_WB.
REQ-051 add with Overflow=1 in R_EXEC -> ALUctr=001; RegWrite=0 in R_WB.
REQ-052 lw with MemReady low 3 cycles in MEM_RD -> MemRead held 4 cycles in MEM_RD; MEM_WB asserts RegWrite=1, MemtoReg=1; 8 cycles total.
REQ-053 beq -> BRANCH with ALUctr=100, PCWriteCond=1, PCSource=01; slt -> ALUctr=111; sltu -> ALUctr=110; ori -> ALUctr=010, ExtOp=0.
REQ-054 Op=111111 -> Illegal=1 for one cycle in DECODE, next state FETCH, no write strobes asserted.
REQ-055 rst_n low during MEM_WR wait -> State=FETCH next cycle, MemWrite=0, OvfHold=0.
